// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve hold, play, pause, scoring and match end.
// All outputs are registered from the next-state decision.
module pong_game_ctrl #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_run,
  output logic               ball_hold,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             start_q;
  logic             pause_q;
  logic             start_arm;
  logic             pause_arm;
  logic             start_re;
  logic             pause_re;
  logic             serve_done;

  // arm flags keep a button held through reset from firing an edge
  assign start_re   = start_btn & ~start_q & start_arm;
  assign pause_re   = pause_btn & ~pause_q & pause_arm;
  assign serve_done = frame_tick && (cnt == CNT_LAST);
  assign state_o    = state;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start_re) nxt = SERVE;
      SERVE: if (serve_done) nxt = PLAY;
      PLAY: begin
        if (miss_left && miss_right)
          nxt = SERVE;
        else if (miss_left || miss_right)
          nxt = POINT;
        else if (pause_re)
          nxt = PAUSE;
      end
      PAUSE: if (pause_re) nxt = PLAY;
      POINT: begin
        if (score_l == WIN || score_r == WIN)
          nxt = OVER;
        else
          nxt = SERVE;
      end
      OVER:  if (start_re) nxt = SERVE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      score_l   <= '0;
      score_r   <= '0;
      ball_run  <= 1'b0;
      ball_hold <= 1'b1;
      serve_dir <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      start_arm <= ~start_btn;
      pause_arm <= ~pause_btn;
    end else begin
      state     <= nxt;
      start_q   <= start_btn;
      pause_q   <= pause_btn;
      if (!start_btn) start_arm <= 1'b1;
      if (!pause_btn) pause_arm <= 1'b1;
      ball_run  <= (nxt == PLAY);
      ball_hold <= nxt inside {IDLE, SERVE, POINT, OVER};
      game_over <= (nxt == OVER);
      unique case (state)
        IDLE, OVER: begin
          if (start_re) begin
            score_l   <= '0;
            score_r   <= '0;
            cnt       <= '0;
            serve_dir <= 1'b0;
          end
        end
        SERVE: begin
          if (frame_tick)
            cnt <= serve_done ? '0 : cnt + 1'b1;
        end
        PLAY: begin
          cnt <= '0;
          if (miss_left && !miss_right) begin
            score_r   <= score_r + 1'b1;
            serve_dir <= 1'b0;
          end else if (miss_right && !miss_left) begin
            score_l   <= score_l + 1'b1;
            serve_dir <= 1'b1;
          end
        end
        POINT: begin
          cnt <= '0;
          if (score_l == WIN)
            winner <= 1'b0;
          else if (score_r == WIN)
            winner <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a per-cycle
// behavioural match model and literal spot checks.
module tb_pong_game_ctrl;

  localparam int SW  = 4;
  localparam int WIN = 9;
  localparam int SF  = 3;

  logic          clk = 0;
  logic          rst = 0;
  logic          frame_tick = 0;
  logic          start_btn = 0;
  logic          pause_btn = 0;
  logic          miss_left = 0;
  logic          miss_right = 0;
  logic          ball_run;
  logic          ball_hold;
  logic          serve_dir;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic          game_over;
  logic          winner;
  logic [2:0]    state_o;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  int m_st, m_sl, m_sr, m_dir, m_win, m_frames;
  int m_sprev, m_pprev;

  pong_game_ctrl #(
    .SCORE_W(SW), .WIN_SCORE(WIN),
    .SERVE_FRAMES(SF), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_tick(frame_tick),
    .start_btn(start_btn),
    .pause_btn(pause_btn),
    .miss_left(miss_left),
    .miss_right(miss_right),
    .ball_run(ball_run),
    .ball_hold(ball_hold),
    .serve_dir(serve_dir),
    .score_l(score_l),
    .score_r(score_r),
    .game_over(game_over),
    .winner(winner),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d",
               name, $time, act, exp);
    end
  endtask

  // Match rules stated directly: a press is a high level
  // after a low one on the previous edge (reset edges too).
  task automatic model_step();
    bit sp, pp;
    sp = start_btn && !m_sprev;
    pp = pause_btn && !m_pprev;
    m_sprev = start_btn;
    m_pprev = pause_btn;
    if (rst) begin
      m_st = 0; m_sl = 0; m_sr = 0;
      m_dir = 0; m_win = 0; m_frames = 0;
    end else begin
      case (m_st)
        0, 5: if (sp) begin
          m_st = 1; m_sl = 0; m_sr = 0;
          m_dir = 0; m_frames = 0;
        end
        1: if (frame_tick) begin
          m_frames++;
          if (m_frames == SF) begin
            m_st = 2; m_frames = 0;
          end
        end
        2: begin
          if (miss_left && miss_right) m_st = 1;
          else if (miss_left) begin
            m_sr++; m_dir = 0; m_st = 4;
          end else if (miss_right) begin
            m_sl++; m_dir = 1; m_st = 4;
          end else if (pp) m_st = 3;
        end
        3: if (pp) m_st = 2;
        4: begin
          if (m_sl == WIN) begin
            m_st = 5; m_win = 0;
          end else if (m_sr == WIN) begin
            m_st = 5; m_win = 1;
          end else begin
            m_st = 1; m_frames = 0;
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_step();
    if (rst) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("state", int'(state_o), m_st);
      chk("score_l", int'(score_l), m_sl);
      chk("score_r", int'(score_r), m_sr);
      chk("serve_dir", int'(serve_dir), m_dir);
      chk("game_over", int'(game_over), int'(m_st == 5));
      chk("winner", int'(winner), m_win);
      if (m_st != 4) begin
        chk("ball_run", int'(ball_run), int'(m_st == 2));
        chk("ball_hold", int'(ball_hold),
            int'(m_st == 0 || m_st == 1 || m_st == 5));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic press_start();
    start_btn = 1; cycle();
    start_btn = 0; cycle();
  endtask

  task automatic press_pause();
    pause_btn = 1; cycle();
    pause_btn = 0; cycle();
  endtask

  task automatic serve_to_play();
    for (int k = 0; k < SF; k++) begin
      frame_tick = 1; cycle();
      frame_tick = 0; cycle();
    end
  endtask

  initial begin
    rst = 1; cycle(); cycle();
    rst = 0;
    chk("rst_state", int'(state_o), 0);
    chk("rst_hold", int'(ball_hold), 1);
    chk("rst_run", int'(ball_run), 0);
    chk("rst_scores", int'({score_l, score_r}), 0);
    chk("rst_over", int'(game_over), 0);
    cycle();

    // tick in the same cycle as the start press is not counted
    start_btn = 1; frame_tick = 1; cycle();
    start_btn = 0; frame_tick = 0; cycle();
    chk("lit_serve", int'(state_o), 1);
    serve_to_play();
    chk("lit_play", int'(state_o), 2);
    chk("lit_run", int'(ball_run), 1);

    for (int i = 0; i < WIN; i++) begin
      miss_left = 1; cycle();
      miss_left = 0;
      chk("lit_point", int'(state_o), 4);
      chk("lit_score_r", int'(score_r), i + 1);
      cycle();
      if (i < WIN - 1) begin
        chk("lit_reserve", int'(state_o), 1);
        serve_to_play();
      end
    end
    chk("lit_over", int'(state_o), 5);
    chk("lit_winner", int'(winner), 1);
    cycle();

    press_start();
    chk("lit_restart", int'(score_r), 0);
    serve_to_play();
    miss_left = 1; miss_right = 1; cycle();
    miss_left = 0; miss_right = 0;
    chk("lit_replay", int'(state_o), 1);
    chk("lit_replay_sc", int'({score_l, score_r}), 0);
    serve_to_play();

    press_pause();
    chk("lit_pause", int'(state_o), 3);
    chk("lit_pause_run", int'(ball_run), 0);
    miss_right = 1; cycle();
    miss_right = 0; cycle();
    chk("lit_pause_sc", int'(score_l), 0);
    start_btn = 1; cycle();
    start_btn = 0; cycle();
    press_pause();
    chk("lit_unpause", int'(state_o), 2);

    // a miss beats a pause press on the same edge
    miss_right = 1; pause_btn = 1; cycle();
    miss_right = 0; pause_btn = 0; cycle();
    serve_to_play();
    for (int i = 1; i < 5; i++) begin
      miss_right = 1; cycle();
      miss_right = 0; cycle();
      serve_to_play();
    end
    chk("lit_score_l5", int'(score_l), 5);
    chk("lit_dir1", int'(serve_dir), 1);

    start_btn = 1; cycle();
    rst = 1; cycle();
    rst = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("lit_held_idle", int'(state_o), 0);
    chk("lit_held_sc", int'(score_l), 0);
    start_btn = 0; cycle();
    press_start();
    chk("lit_rearm", int'(state_o), 1);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
